// File: rtl/decode_ibuf.sv
`default_nettype none
// ============================================================================
// Module   : decode_ibuf
// Purpose  : Instruction buffer between the fetch memory port and decode.
//            Captures fetched words (instr/pc/exc), holds them while decode
//            stalls and presents them in order. Fetch is throttled by credits
//            (buffered + in-flight < DEPTH). Flushes toggle an epoch so stale
//            in-flight responses are dropped on arrival.
// Ports    : clk, rst (async, active high), clk_en
//            flush                         - discard entries, toggle epoch
//            fetch_issue / fetch_ready     - request issue / credit available
//            epoch                         - tag for new fetch requests
//            in_valid/in_epoch/in_instr/in_pc/in_exc - memory response
//            out_ready/out_valid/out_instr/out_pc/out_exc - decode side
//            overflow                      - sticky: response hit a full buffer
// Config   : DECODE_IBUF_BYPASS_EN - when defined, an accepted response into
//            an empty buffer is presented on out_* in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module decode_ibuf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic          flush,
    input  logic          fetch_issue,
    output logic          fetch_ready,
    output logic          epoch,
    input  logic          in_valid,
    input  logic          in_epoch,
    input  logic [IW-1:0] in_instr,
    input  logic [31:0]   in_pc,
    input  logic [7:0]    in_exc,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [IW-1:0] out_instr,
    output logic [31:0]   out_pc,
    output logic [7:0]    out_exc,
    output logic          overflow
);

    localparam int unsigned C_PTR_W = $clog2(DEPTH);
    localparam int unsigned C_CNT_W = $clog2(DEPTH + 1);
    localparam logic [C_CNT_W-1:0] C_FULL  = C_CNT_W'(DEPTH);
    localparam logic [C_CNT_W:0]   C_LIMIT = (C_CNT_W + 1)'(DEPTH);

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [31:0]   pc;
        logic [7:0]    exc;
    } entry_t;

    entry_t mem_q [DEPTH];

    logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_CNT_W-1:0] count_q, count_d;
    logic [C_CNT_W-1:0] inflight_q, inflight_d;
    logic               epoch_q, epoch_d;
    logic               overflow_q, overflow_d;

    logic               w_empty;
    logic               w_full;
    logic               w_accept;
    logic               w_bypass;
    logic               w_bypass_take;
    logic               w_pop_buf;
    logic               w_push;
    logic               w_ovf;
    logic [C_CNT_W:0]   w_credit_sum;
    entry_t             w_head;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        w_empty   = (count_q == '0);
        w_full    = (count_q == C_FULL);
        w_accept  = in_valid && (in_epoch == epoch_q) && !flush;
`ifdef DECODE_IBUF_BYPASS_EN
        w_bypass  = w_empty && w_accept;
`else
        w_bypass  = 1'b0;
`endif
        // A bypassed word taken by decode the same cycle never enters storage.
        w_bypass_take = w_bypass && out_ready;
        w_pop_buf     = !w_empty && out_ready && !flush;
        // A full buffer can still take a word when the head leaves this cycle.
        w_push        = w_accept && !w_bypass_take && (!w_full || w_pop_buf);
        w_ovf         = w_accept && w_full && !w_pop_buf;
        // One bit wider than count so the credit compare cannot wrap.
        w_credit_sum  = {1'b0, count_q} + {1'b0, inflight_q};
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        epoch_d    = epoch_q;
        overflow_d = overflow_q;

        if (clk_en) begin
            if (w_pop_buf) begin
                rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
            end
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
            end
            case ({w_push, w_pop_buf})
                2'b10:   count_d = count_q + C_CNT_W'(1);
                2'b01:   count_d = count_q - C_CNT_W'(1);
                default: count_d = count_q;
            endcase

            // Every response returns a credit regardless of epoch. The
            // decrement saturates so a response arriving without a tracked
            // request (e.g. one issued before reset) cannot wrap the counter.
            if (fetch_issue && !in_valid) begin
                inflight_d = inflight_q + C_CNT_W'(1);
            end else if (!fetch_issue && in_valid && (inflight_q != '0)) begin
                inflight_d = inflight_q - C_CNT_W'(1);
            end

            if (w_ovf) begin
                overflow_d = 1'b1;
            end

            // In-flight credits survive a flush: stale responses are owed.
            if (flush) begin
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                count_d  = '0;
                epoch_d  = ~epoch_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            epoch_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            epoch_q    <= epoch_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage (contents intentionally not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clk_en && w_push) begin
            mem_q[wr_ptr_q] <= '{instr: in_instr, pc: in_pc, exc: in_exc};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_head      = mem_q[rd_ptr_q];
        out_valid   = !w_empty || w_bypass;
        out_instr   = w_bypass ? in_instr : w_head.instr;
        out_pc      = w_bypass ? in_pc    : w_head.pc;
        out_exc     = w_bypass ? in_exc   : w_head.exc;
        fetch_ready = (w_credit_sum < C_LIMIT);
        epoch       = epoch_q;
        overflow    = overflow_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_ibuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_ibuf
// Purpose  : Self-checking bench for decode_ibuf (DEPTH=4, IW=32). Stimulus
//            pushes expected head entries into a scoreboard queue; a monitor
//            pops and compares on every decode handshake. State flags are
//            checked directly against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_ibuf;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned IW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          clk_en;
    logic          flush;
    logic          fetch_issue;
    logic          fetch_ready;
    logic          epoch;
    logic          in_valid;
    logic          in_epoch;
    logic [IW-1:0] in_instr;
    logic [31:0]   in_pc;
    logic [7:0]    in_exc;
    logic          out_ready;
    logic          out_valid;
    logic [IW-1:0] out_instr;
    logic [31:0]   out_pc;
    logic [7:0]    out_exc;
    logic          overflow;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [7:0]  exc;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    decode_ibuf #(.DEPTH(DEPTH), .IW(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .flush      (flush),
        .fetch_issue(fetch_issue),
        .fetch_ready(fetch_ready),
        .epoch      (epoch),
        .in_valid   (in_valid),
        .in_epoch   (in_epoch),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .in_exc     (in_exc),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_exc    (out_exc),
        .overflow   (overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every decode handshake consumes the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && clk_en && out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_out: got instr %0h pc %0h expected no output", out_instr, out_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_total++;
                if (out_instr === e.instr && out_pc === e.pc && out_exc === e.exc) n_pass++;
                else $display("FAIL sb_out: got %0h/%0h/%0h expected %0h/%0h/%0h",
                              out_instr, out_pc, out_exc, e.instr, e.pc, e.exc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int n);
        for (int k = 0; k < n; k++) begin
            fetch_issue = 1'b1;
            tick();
        end
        fetch_issue = 1'b0;
    endtask

    task automatic resp(input logic ep, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [7:0] exc, input bit keep);
        in_valid = 1'b1;
        in_epoch = ep;
        in_instr = ins;
        in_pc    = pc;
        in_exc   = exc;
        if (keep) sb.push_back('{instr: ins, pc: pc, exc: exc});
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clk_en = 1'b1; flush = 1'b0; fetch_issue = 1'b0;
        in_valid = 1'b0; in_epoch = 1'b0; in_instr = '0; in_pc = '0; in_exc = '0;
        out_ready = 1'b0;
        #2;
        chk("rst_out_valid",   out_valid,   0);
        chk("rst_fetch_ready", fetch_ready, 1);
        chk("rst_overflow",    overflow,    0);
        chk("rst_epoch",       epoch,       0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // clk_en low: issue and response are both ignored
        clk_en = 1'b0; fetch_issue = 1'b1;
        in_valid = 1'b1; in_epoch = 1'b0; in_instr = 32'h99; in_pc = 32'h0;
        tick();
        fetch_issue = 1'b0; in_valid = 1'b0;
        #1;
        chk("clken_out_valid", out_valid, 0);
        clk_en = 1'b1;

        // Fill and drain
        issue(4);
        #1 chk("fill_fetch_ready_0", fetch_ready, 0);
        resp(0, 32'h11, 32'h0, 8'h0, 1);
        resp(0, 32'h22, 32'h4, 8'h0, 1);
        resp(0, 32'h33, 32'h8, 8'h0, 1);
        resp(0, 32'h44, 32'hC, 8'h0, 1);
        #1;
        chk("fill_fetch_ready_full", fetch_ready, 0);
        chk("fill_head_instr",       out_instr,   32'h11);
        repeat (3) tick();
        chk("stall_head_stable",     out_instr,   32'h11);
        out_ready = 1'b1;
        tick();
        chk("drain_fetch_ready_1",   fetch_ready, 1);
        repeat (3) tick();
        out_ready = 1'b0;
        #1 chk("drain_empty", out_valid, 0);

        // Wrap-around: continuous issue/return/pop
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            fetch_issue = 1'b1;
            in_valid = 1'b1; in_epoch = 1'b0;
            in_instr = 32'h1000 + i; in_pc = 32'h100 + 4 * i; in_exc = 8'(i + 1);
            sb.push_back('{instr: 32'h1000 + i, pc: 32'h100 + 4 * i, exc: 8'(i + 1)});
            tick();
        end
        fetch_issue = 1'b0; in_valid = 1'b0;
        repeat (2) tick();
        out_ready = 1'b0;
        #1;
        chk("wrap_empty",       out_valid,   0);
        chk("wrap_fetch_ready", fetch_ready, 1);

        // Flush with stale responses in flight
        issue(2);
        resp(0, 32'h61, 32'h300, 8'h0, 1);
        resp(0, 32'h62, 32'h304, 8'h0, 1);
        issue(2);
        flush = 1'b1;
        sb.delete();
        tick();
        flush = 1'b0;
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_epoch",     epoch,     1);
        resp(0, 32'hBAD0, 32'h308, 8'h0, 0);
        resp(0, 32'hBAD1, 32'h30C, 8'h0, 0);
        #1 chk("stale_dropped", out_valid, 0);
        issue(1);
        resp(1, 32'hABCD, 32'h200, 8'h0C, 1);
        #1;
        chk("new_epoch_valid", out_valid, 1);
        chk("new_epoch_instr", out_instr, 32'hABCD);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1 chk("new_epoch_drained", out_valid, 0);
        // Credits: stale responses must have returned theirs
        issue(3);
        #1 chk("credit_after_3", fetch_ready, 1);
        issue(1);
        #1 chk("credit_after_4", fetch_ready, 0);

        // Full buffer with simultaneous push and pop
        resp(1, 32'h71, 32'h400, 8'h0, 1);
        resp(1, 32'h72, 32'h404, 8'h0, 1);
        resp(1, 32'h73, 32'h408, 8'h0, 1);
        resp(1, 32'h74, 32'h40C, 8'h0, 1);
        in_valid = 1'b1; in_epoch = 1'b1; in_instr = 32'h75; in_pc = 32'h410; in_exc = 8'h0;
        sb.push_back('{instr: 32'h75, pc: 32'h410, exc: 8'h0});
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("fullpp_overflow",    overflow,    0);
        chk("fullpp_fetch_ready", fetch_ready, 0);
        chk("fullpp_head",        out_instr,   32'h72);

        // Overflow: push into full buffer without pop
        resp(1, 32'hDEAD, 32'h500, 8'h0, 0);
        #1 chk("ovf_set", overflow, 1);
        repeat (3) tick();
        chk("ovf_sticky", overflow, 1);
        chk("ovf_head",   out_instr, 32'h72);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        #1;
        chk("ovf_drained",      out_valid, 0);
        chk("ovf_still_sticky", overflow,  1);

        // Response latency / bypass
        issue(1);
        out_ready = 1'b1;
        in_valid = 1'b1; in_epoch = 1'b1; in_instr = 32'h5A5A; in_pc = 32'h600; in_exc = 8'h0;
        sb.push_back('{instr: 32'h5A5A, pc: 32'h600, exc: 8'h0});
        #1;
`ifdef DECODE_IBUF_BYPASS_EN
        chk("bypass_valid", out_valid, 1);
        chk("bypass_instr", out_instr, 32'h5A5A);
        tick();
        in_valid = 1'b0;
        #1 chk("bypass_not_stored", out_valid, 0);
`else
        chk("nobypass_same_cycle", out_valid, 0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("nobypass_next_valid", out_valid, 1);
        chk("nobypass_next_instr", out_instr, 32'h5A5A);
        tick();
        #1 chk("nobypass_drained", out_valid, 0);
`endif
        out_ready = 1'b0;

        // Asynchronous reset mid-cycle clears the sticky flag immediately
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_overflow", overflow, 0);
        chk("arst_epoch",    epoch,    0);
        @(posedge clk);
        #1 rst = 1'b0;

        chk("sb_empty", 64'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
